// File: rtl/approx_mul_pkg.sv
// Shared types and elaboration-time helpers for the approximate signed multiplier.
package approx_mul_pkg;

   typedef enum logic [1:0] {
      MODE_EXACT        = 2'b00,
      MODE_TRUNC        = 2'b01,
      MODE_TRUNC_STATIC = 2'b10,
      MODE_TRUNC_PROG   = 2'b11
   } mode_e;

   localparam int MAX_W = 32;

   // Bit c set means product column c survives truncation.
   function automatic logic [MAX_W-1:0] col_keep_mask(input int n, input int t);
      logic [MAX_W-1:0] m;
      m = '0;
      for (int c = 0; c < 2 * n; c++) begin
         if (c >= t) m[c] = 1'b1;
      end
      return m;
   endfunction

   // Baugh-Wooley correction: +2^n and +2^(2n-1), absorbing the inverted sign rows.
   function automatic logic [MAX_W-1:0] bw_const(input int n);
      logic [MAX_W-1:0] m;
      m = '0;
      m[n]       = 1'b1;
      m[2*n - 1] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/approx_mul_pp.sv
// Baugh-Wooley partial-product array with column truncation and compensation,
// reduced to a redundant sum/carry pair by a chain of full-adder rows.
module approx_mul_pp
   import approx_mul_pkg::*;
#(
   parameter int N    = 8,
   parameter int T    = 5,
   parameter int CW   = 3,
   parameter int COMP = 4
) (
   input  logic [N-1:0]   a_i,
   input  logic [N-1:0]   b_i,
   input  logic [1:0]     mode_i,
   input  logic [CW-1:0]  comp_i,
   output logic [2*N-1:0] sum_o,
   output logic [2*N-1:0] carry_o
);

   localparam int W = 2 * N;
   localparam logic [W-1:0] KEEP = W'(col_keep_mask(N, T));
   localparam logic [W-1:0] BW   = W'(bw_const(N));

   mode_e         mode;
   logic          trunc;
   logic          pp_bit;
   logic [CW-1:0] comp_v;
   logic [W-1:0]  row;
   logic [W-1:0]  s_v;
   logic [W-1:0]  c_v;
   logic [W-1:0]  carry_n;

   // NOTE: every variable gets a default at the top of the block, so no path leaves one unassigned (no latch).
   always_comb begin
      mode    = mode_e'(mode_i);
      trunc   = (mode != MODE_EXACT);
      comp_v  = '0;
      pp_bit  = 1'b0;
      row     = '0;
      carry_n = '0;
      unique case (mode)
         MODE_TRUNC_STATIC: comp_v = CW'(COMP);
         MODE_TRUNC_PROG:   comp_v = comp_i;
         default:           comp_v = '0;
      endcase

      // Seed the accumulator with the constant row, then fold in the compensation row.
      s_v = BW;
      c_v = '0;
      for (int k = 0; k < CW; k++) begin
         if (k + T < W) row[k+T] = comp_v[k];
      end
      carry_n = ((s_v & c_v) | (s_v & row) | (c_v & row)) << 1;
      s_v     = s_v ^ c_v ^ row;
      c_v     = carry_n;

      for (int j = 0; j < N; j++) begin
         row = '0;
         for (int i = 0; i < N; i++) begin
            if (i == N - 1 && j == N - 1)
               pp_bit = a_i[i] & b_i[j];
            else if (i == N - 1 || j == N - 1)
               pp_bit = ~(a_i[i] & b_i[j]);
            else
               pp_bit = a_i[i] & b_i[j] & (!trunc || KEEP[i+j]);
            row[i+j] = pp_bit;
         end
         carry_n = ((s_v & c_v) | (s_v & row) | (c_v & row)) << 1;
         s_v     = s_v ^ c_v ^ row;
         c_v     = carry_n;
      end

      sum_o   = s_v;
      carry_o = c_v;
   end

endmodule

// File: rtl/approx_mul_pipe.sv
// Three-stage valid/ready pipelined approximate multiplier with programmable
// compensation, tag/mode sideband and an output transfer counter.
module approx_mul_pipe
   import approx_mul_pkg::*;
#(
   parameter int N    = 8,
   parameter int T    = 5,
   parameter int CW   = 3,
   parameter int COMP = 4,
   parameter int TAGW = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    in_a,
   input  logic [N-1:0]    in_b,
   input  logic [1:0]      in_mode,
   input  logic [TAGW-1:0] in_tag,
   input  logic            cfg_we,
   input  logic [CW-1:0]   cfg_comp,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [2*N-1:0]  out_p,
   output logic [TAGW-1:0] out_tag,
   output logic [1:0]      out_mode,
   output logic [31:0]     res_count
);

   localparam int W = 2 * N;

   logic            advance;
   logic            out_xfer;

   logic            v1_q;
   logic [N-1:0]    a1_q, b1_q;
   logic [1:0]      mode1_q;
   logic [TAGW-1:0] tag1_q;
   logic [CW-1:0]   comp1_q;
   logic [CW-1:0]   comp_reg_q, comp_reg_d;

   logic            v2_q;
   logic [W-1:0]    sum2_q, carry2_q, sum_d, carry_d;
   logic [1:0]      mode2_q;
   logic [TAGW-1:0] tag2_q;

   logic            v3_q;
   logic [W-1:0]    p3_q, p3_d;
   logic [1:0]      mode3_q;
   logic [TAGW-1:0] tag3_q;
   logic [31:0]     count_q, count_d;

   // One global enable: the whole pipe moves or holds together, bubbles included.
   assign advance  = !v3_q || out_ready;
   assign in_ready = advance;
   assign out_xfer = v3_q && out_ready;

   approx_mul_pp #(
      .N    (N),
      .T    (T),
      .CW   (CW),
      .COMP (COMP)
   ) u_pp (
      .a_i     (a1_q),
      .b_i     (b1_q),
      .mode_i  (mode1_q),
      .comp_i  (comp1_q),
      .sum_o   (sum_d),
      .carry_o (carry_d)
   );

   always_comb begin
      comp_reg_d = cfg_we ? cfg_comp : comp_reg_q;
      p3_d       = sum2_q + carry2_q;
      count_d    = count_q + 32'(out_xfer);
   end

   // NOTE: reset is synchronous and clears datapath registers as well, so no X ever reaches out_p.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q       <= 1'b0;
         a1_q       <= '0;
         b1_q       <= '0;
         mode1_q    <= '0;
         tag1_q     <= '0;
         comp1_q    <= '0;
         comp_reg_q <= CW'(COMP);
         v2_q       <= 1'b0;
         sum2_q     <= '0;
         carry2_q   <= '0;
         mode2_q    <= '0;
         tag2_q     <= '0;
         v3_q       <= 1'b0;
         p3_q       <= '0;
         mode3_q    <= '0;
         tag3_q     <= '0;
         count_q    <= '0;
      end else begin
         comp_reg_q <= comp_reg_d;
         count_q    <= count_d;
         if (advance) begin
            // comp_reg is captured with the beat, so a same-cycle write is seen one beat later.
            v1_q     <= in_valid;
            a1_q     <= in_a;
            b1_q     <= in_b;
            mode1_q  <= in_mode;
            tag1_q   <= in_tag;
            comp1_q  <= comp_reg_q;
            v2_q     <= v1_q;
            sum2_q   <= sum_d;
            carry2_q <= carry_d;
            mode2_q  <= mode1_q;
            tag2_q   <= tag1_q;
            v3_q     <= v2_q;
            p3_q     <= p3_d;
            mode3_q  <= mode2_q;
            tag3_q   <= tag2_q;
         end
      end
   end

   assign out_valid = v3_q;
   assign out_p     = p3_q;
   assign out_tag   = tag3_q;
   assign out_mode  = mode3_q;
   assign res_count = count_q;

endmodule
